// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: resolves memory waits, multiply
// occupancy of EX, taken branches and load-use hazards in fixed priority order.
module pipe_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int REG_W   = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memReadE,
  input  logic [REG_W-1:0] rdE,
  input  logic [REG_W-1:0] rs1D,
  input  logic [REG_W-1:0] rs2D,
  input  logic             pcSrcE,
  input  logic             mulStartE,
  input  logic             memBusyM,
  output logic             pcEn,
  output logic             enF,
  output logic             clrF,
  output logic             enD,
  output logic             clrD,
  output logic             enE,
  output logic             clrE,
  output logic             enM,
  output logic             clrM,
  output logic             mulDoneE,
  output logic [15:0]      stallCnt,
  output logic [15:0]      flushCnt
);

  localparam int CW = (MUL_LAT > 2) ? $clog2(MUL_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(MUL_LAT - 2);

  typedef enum logic {RUN, MUL_WAIT} state_t;

  state_t        state, stateNext;
  logic [CW-1:0] cnt, cntNext;
  logic          loadUse, mulHold, mulRelease, flushNow;

  assign loadUse    = memReadE && (rdE != '0) && ((rdE == rs1D) || (rdE == rs2D));
  assign mulHold    = ((state == RUN) && mulStartE) || ((state == MUL_WAIT) && (cnt != '0));
  assign mulRelease = (state == MUL_WAIT) && (cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= stateNext;
      cnt   <= cntNext;
    end
  end

  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    pcEn      = 1'b1;
    enF       = 1'b1;
    clrF      = 1'b0;
    enD       = 1'b1;
    clrD      = 1'b0;
    enE       = 1'b1;
    clrE      = 1'b0;
    enM       = 1'b1;
    clrM      = 1'b0;
    mulDoneE  = 1'b0;
    flushNow  = 1'b0;

    if (rst) begin
      pcEn = 1'b0;
      enF  = 1'b0;
      enD  = 1'b0;
      enE  = 1'b0;
      enM  = 1'b0;
    end else if (memBusyM) begin
      // Freeze everything up to MEM; WB receives a bubble, FSM holds.
      pcEn = 1'b0;
      enF  = 1'b0;
      enD  = 1'b0;
      enE  = 1'b0;
      clrM = 1'b1;
    end else if (mulHold) begin
      pcEn = 1'b0;
      enF  = 1'b0;
      enD  = 1'b0;
      clrE = 1'b1;
      if (state == RUN) begin
        stateNext = MUL_WAIT;
        cntNext   = CNT_INIT;
      end else begin
        cntNext = cnt - CW'(1);
      end
    end else if (mulRelease) begin
      mulDoneE  = 1'b1;
      stateNext = RUN;
    end else if (pcSrcE) begin
      clrF     = 1'b1;
      clrD     = 1'b1;
      flushNow = 1'b1;
    end else if (loadUse) begin
      pcEn = 1'b0;
      enF  = 1'b0;
      clrD = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      if (!pcEn)
        stallCnt <= stallCnt + 16'd1;
      if (flushNow)
        flushCnt <= flushCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: expected control vectors are queued when
// stimulus is driven and compared against the DUT mid-cycle.
module tb_pipe_hazard_ctrl;

  logic        clk, rst;
  logic        memReadE, pcSrcE, mulStartE, memBusyM;
  logic [4:0]  rdE, rs1D, rs2D;
  logic        pcEn, enF, clrF, enD, clrD, enE, clrE, enM, clrM, mulDoneE;
  logic [15:0] stallCnt, flushCnt;
  logic [9:0]  obs;

  // Bit order: pcEn enF clrF enD clrD enE clrE enM clrM mulDoneE
  localparam logic [9:0] RST_V  = 10'b0000000000;
  localparam logic [9:0] DEF_V  = 10'b1101010100;
  localparam logic [9:0] LU_V   = 10'b0001110100;
  localparam logic [9:0] BR_V   = 10'b1111110100;
  localparam logic [9:0] MUL_V  = 10'b0000011100;
  localparam logic [9:0] BUSY_V = 10'b0000000110;
  localparam logic [9:0] DONE_V = 10'b1101010101;

  logic [9:0]  expQ[$];
  logic [9:0]  got;
  int          nCmp = 0;
  int          nErr = 0;
  int          expStall = 0;
  int          expFlush = 0;

  pipe_hazard_ctrl #(.MUL_LAT(4), .REG_W(5)) dut (
    .clk(clk), .rst(rst), .memReadE(memReadE), .rdE(rdE), .rs1D(rs1D), .rs2D(rs2D),
    .pcSrcE(pcSrcE), .mulStartE(mulStartE), .memBusyM(memBusyM),
    .pcEn(pcEn), .enF(enF), .clrF(clrF), .enD(enD), .clrD(clrD), .enE(enE), .clrE(clrE),
    .enM(enM), .clrM(clrM), .mulDoneE(mulDoneE), .stallCnt(stallCnt), .flushCnt(flushCnt)
  );

  assign obs = {pcEn, enF, clrF, enD, clrD, enE, clrE, enM, clrM, mulDoneE};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drive one cycle of inputs and queue what the controller must produce for it.
  task automatic apply(input logic mr, input logic [4:0] rd, input logic [4:0] r1,
                       input logic [4:0] r2, input logic ps, input logic ms,
                       input logic mb, input logic [9:0] exp);
    memReadE  = mr;
    rdE       = rd;
    rs1D      = r1;
    rs2D      = r2;
    pcSrcE    = ps;
    mulStartE = ms;
    memBusyM  = mb;
    expQ.push_back(exp);
    if (!exp[9]) expStall++;
    if (exp == BR_V) expFlush++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, RST_V);
    expStall = 0;
    #1;
    got = expQ.pop_front();
    nCmp++;
    if (obs !== got) begin
      nErr++;
      $display("FAIL reset_outputs: got %b want %b", obs, got);
    end
    nCmp++;
    if (stallCnt !== 16'd0 || flushCnt !== 16'd0) begin
      nErr++;
      $display("FAIL reset_counters: got stall=%0d flush=%0d want 0/0", stallCnt, flushCnt);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    $display("reset released at %0t", $time);
  endtask

  task automatic test_load_use();
    logic [4:0] r1Tab[4] = '{5'd5, 5'd0, 5'd3, 5'd7};
    logic [4:0] r2Tab[4] = '{5'd1, 5'd0, 5'd9, 5'd9};
    logic [4:0] rdTab[4] = '{5'd5, 5'd0, 5'd9, 5'd4};
    logic [9:0] eTab[4]  = '{LU_V, DEF_V, LU_V, DEF_V};
    for (int i = 0; i < 4; i++) begin
      apply(1'b1, rdTab[i], r1Tab[i], r2Tab[i], 1'b0, 1'b0, 1'b0, eTab[i]);
      @(negedge clk);
      got = expQ.pop_front();
      nCmp++;
      if (obs !== got) begin
        nErr++;
        $display("FAIL load_use[%0d]: got %b want %b", i, obs, got);
      end else
        $display("load_use[%0d] rd=%0d rs1=%0d rs2=%0d ctrl=%b", i, rdTab[i], r1Tab[i], r2Tab[i], obs);
      @(posedge clk); #1;
      if (i == 0) begin
        nCmp++;
        if (stallCnt !== 16'(expStall)) begin
          nErr++;
          $display("FAIL load_use_stallcnt: got %0d want %0d", stallCnt, expStall);
        end
      end
    end
  endtask

  task automatic test_branch();
    logic [9:0] eTab[2] = '{BR_V, DEF_V};
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 5'd0, 5'd0, 5'd0, (i == 0), 1'b0, 1'b0, eTab[i]);
      @(negedge clk);
      got = expQ.pop_front();
      nCmp++;
      if (obs !== got) begin
        nErr++;
        $display("FAIL branch[%0d]: got %b want %b", i, obs, got);
      end else
        $display("branch[%0d] ctrl=%b", i, obs);
      @(posedge clk); #1;
      nCmp++;
      if (flushCnt !== 16'(expFlush)) begin
        nErr++;
        $display("FAIL branch_flushcnt[%0d]: got %0d want %0d", i, flushCnt, expFlush);
      end
    end
  endtask

  task automatic test_multiply();
    int stallBefore;
    stallBefore = expStall;
    for (int i = 0; i < 5; i++) begin
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, (i < 4), 1'b0,
            (i < 3) ? MUL_V : ((i == 3) ? DONE_V : DEF_V));
      @(negedge clk);
      got = expQ.pop_front();
      nCmp++;
      if (obs !== got) begin
        nErr++;
        $display("FAIL multiply[%0d]: got %b want %b", i, obs, got);
      end else
        $display("multiply cycle %0d ctrl=%b", i + 1, obs);
      @(posedge clk); #1;
    end
    nCmp++;
    if (stallCnt !== 16'(stallBefore + 3)) begin
      nErr++;
      $display("FAIL multiply_stallcnt: got %0d want %0d", stallCnt, stallBefore + 3);
    end
  endtask

  task automatic test_mul_mem_wait();
    logic [9:0] eTab[7] = '{MUL_V, MUL_V, BUSY_V, BUSY_V, MUL_V, DONE_V, DEF_V};
    for (int i = 0; i < 7; i++) begin
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, (i < 6), (i == 2 || i == 3), eTab[i]);
      @(negedge clk);
      got = expQ.pop_front();
      nCmp++;
      if (obs !== got) begin
        nErr++;
        $display("FAIL mul_mem_wait[%0d]: got %b want %b", i, obs, got);
      end else
        $display("mul_mem_wait cycle %0d busy=%0b ctrl=%b", i + 1, memBusyM, obs);
      @(posedge clk); #1;
    end
    nCmp++;
    if (stallCnt !== 16'(expStall)) begin
      nErr++;
      $display("FAIL mul_mem_wait_stallcnt: got %0d want %0d", stallCnt, expStall);
    end
  endtask

  task automatic test_priority();
    logic [9:0] eTab[4] = '{BUSY_V, BUSY_V, LU_V, DEF_V};
    for (int i = 0; i < 4; i++) begin
      apply((i < 3), 5'd6, 5'd2, 5'd6, 1'b0, 1'b0, (i < 2), eTab[i]);
      @(negedge clk);
      got = expQ.pop_front();
      nCmp++;
      if (obs !== got) begin
        nErr++;
        $display("FAIL priority[%0d]: got %b want %b", i, obs, got);
      end else
        $display("priority cycle %0d busy=%0b ctrl=%b", i + 1, memBusyM, obs);
      @(posedge clk); #1;
    end
  endtask

  task automatic test_back_to_back();
    // branch, branch, busy with mul pending, then a full multiply, then idle
    logic       psTab[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic       msTab[8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic       mbTab[8] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [9:0] eTab[8]  = '{BR_V, BR_V, BUSY_V, MUL_V, MUL_V, MUL_V, DONE_V, DEF_V};
    for (int i = 0; i < 8; i++) begin
      apply(1'b0, 5'd0, 5'd0, 5'd0, psTab[i], msTab[i], mbTab[i], eTab[i]);
      @(negedge clk);
      got = expQ.pop_front();
      nCmp++;
      if (obs !== got) begin
        nErr++;
        $display("FAIL back_to_back[%0d]: got %b want %b", i, obs, got);
      end else
        $display("back_to_back cycle %0d ctrl=%b", i + 1, obs);
      @(posedge clk); #1;
    end
    nCmp++;
    if (stallCnt !== 16'(expStall) || flushCnt !== 16'(expFlush)) begin
      nErr++;
      $display("FAIL back_to_back_counters: got %0d/%0d want %0d/%0d",
               stallCnt, flushCnt, expStall, expFlush);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 2; i++) begin
      apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, MUL_V);
      @(negedge clk);
      got = expQ.pop_front();
      nCmp++;
      if (obs !== got) begin
        nErr++;
        $display("FAIL async_reset_mul[%0d]: got %b want %b", i, obs, got);
      end
      @(posedge clk); #1;
    end
    // now in MUL_WAIT with cnt = 1; reset must act without waiting for an edge
    rst = 1'b1;
    expQ.push_back(RST_V);
    #1;
    got = expQ.pop_front();
    nCmp++;
    if (obs !== got || stallCnt !== 16'd0 || flushCnt !== 16'd0) begin
      nErr++;
      $display("FAIL async_reset_now: got %b %0d/%0d want %b 0/0", obs, stallCnt, flushCnt, got);
    end else
      $display("async reset mid-multiply ctrl=%b", obs);
    expStall = 0;
    expFlush = 0;
    #1;
    rst = 1'b0;
    apply(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, DEF_V);
    @(negedge clk);
    got = expQ.pop_front();
    nCmp++;
    if (obs !== got) begin
      nErr++;
      $display("FAIL async_reset_release: got %b want %b", obs, got);
    end
    @(posedge clk); #1;
    nCmp++;
    if (stallCnt !== 16'(expStall) || flushCnt !== 16'(expFlush)) begin
      nErr++;
      $display("FAIL async_reset_counters: got %0d/%0d want %0d/%0d",
               stallCnt, flushCnt, expStall, expFlush);
    end
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_multiply();
    test_mul_mem_wait();
    test_priority();
    test_back_to_back();
    test_async_reset();
    nCmp++;
    if (expQ.size() != 0) begin
      nErr++;
      $display("FAIL scoreboard_drain: got %0d left want 0", expQ.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

endmodule
